// File: rtl/axi_lite_mem_pkg.sv
// Shared types for the AXI4-Lite memory slave: response codes, FSM states and address decode.
package axi_lite_mem_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic {
        WR_IDLE,
        WR_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_WAIT,
        RD_DATA
    } rd_state_t;

    // Byte address to word index; low (sub-word) address bits are discarded.
    function automatic logic [63:0] word_index(input logic [63:0] addr, input logic [63:0] base,
                                               input int unsigned bytes);
        logic [63:0] off;
        off = addr - base;
        return (bytes == 8) ? (off >> 3) : (off >> 2);
    endfunction

endpackage

// File: rtl/axi_lite_mem_slv_if.sv
// AXI4-Lite bus bundle between a master and the memory slave.
interface axi_lite_mem_slv_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_mem_array.sv
// DEPTH x DATA_W memory: one byte-enabled write port, one registered read port, write-first.
module axi_lite_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = 10
) (
    input  logic                aclk,
    input  logic                we,
    input  logic [IDX_W-1:0]    waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                re,
    input  logic [IDX_W-1:0]    raddr,
    output logic [DATA_W-1:0]   rdata
);
    localparam int STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // A read hitting the word being written sees the new bytes on enabled lanes.
    always_ff @(posedge aclk) begin
        for (int b = 0; b < STRB_W; b++) begin
            if (we && wstrb[b])
                mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            if (re)
                rdata[8*b +: 8] <= (we && wstrb[b] && (waddr == raddr)) ? wdata[8*b +: 8]
                                                                         : mem[raddr][8*b +: 8];
        end
    end
endmodule

// File: rtl/axi_lite_mem_slv.sv
// AXI4-Lite slave backed by a word-addressed memory with range decode and configurable read latency.
// Define AXI_LITE_MEM_STATS_EN to add saturating wr_count / rd_count / err_count outputs.
module axi_lite_mem_slv
    import axi_lite_mem_pkg::*;
#(
    parameter int              DATA_W     = 32,
    parameter int              ADDR_W     = 16,
    parameter int              DEPTH      = 1024,
    parameter int              RD_LATENCY = 1,
    parameter longint unsigned BASE_ADDR  = 0
) (
    input  logic aclk,
    input  logic aresetn,
    axi_lite_mem_slv_if.slave s
`ifdef AXI_LITE_MEM_STATS_EN
    ,
    output logic [31:0] wr_count,
    output logic [31:0] rd_count,
    output logic [31:0] err_count
`endif
);
    localparam int          STRB_W   = DATA_W / 8;
    localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [63:0] DEPTH64  = 64'(DEPTH);
    localparam logic [3:0]  LAT_LOAD = 4'(RD_LATENCY - 1);

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (64'(a) >= BASE_ADDR) && (word_index(64'(a), BASE_ADDR, STRB_W) < DEPTH64);
    endfunction

    // Readies stay low while in reset and rise on the first edge after release.
    logic live;
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) live <= 1'b0;
        else          live <= 1'b1;

    wr_state_t           wr_st, wr_nx;
    logic                aw_got, w_got, commit, aw_ok;
    logic [ADDR_W-1:0]   aw_addr;
    logic [DATA_W-1:0]   w_data;
    logic [STRB_W-1:0]   w_strb;
    resp_t               bresp_q;

    assign commit  = (wr_st == WR_IDLE) && aw_got && w_got;
    assign aw_ok   = addr_ok(aw_addr);
    assign s.bresp = bresp_q;

    always_comb begin
        wr_nx     = wr_st;
        s.awready = 1'b0;
        s.wready  = 1'b0;
        s.bvalid  = 1'b0;
        case (wr_st)
            WR_IDLE: begin
                s.awready = live && !aw_got;
                s.wready  = live && !w_got;
                if (commit) wr_nx = WR_RESP;
            end
            WR_RESP: begin
                s.bvalid = 1'b1;
                if (s.bready) wr_nx = WR_IDLE;
            end
            default: wr_nx = WR_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_st   <= WR_IDLE;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            bresp_q <= OKAY;
        end else begin
            wr_st <= wr_nx;
            if (s.awvalid && s.awready) begin
                aw_got  <= 1'b1;
                aw_addr <= s.awaddr;
            end
            if (s.wvalid && s.wready) begin
                w_got  <= 1'b1;
                w_data <= s.wdata;
                w_strb <= s.wstrb;
            end
            if (commit) begin
                aw_got  <= 1'b0;
                w_got   <= 1'b0;
                bresp_q <= aw_ok ? OKAY : DECERR;
            end
        end
    end

    rd_state_t           rd_st, rd_nx;
    logic [3:0]          rd_cnt;
    logic [ADDR_W-1:0]   ar_addr, rd_addr;
    logic                ar_hs, rd_sample, rd_ok;
    resp_t               rresp_q;
    logic [DATA_W-1:0]   rd_q;

    // Latency 1 samples memory on the AR edge itself, so decode the live address then.
    assign ar_hs     = s.arvalid && live && (rd_st == RD_IDLE);
    assign rd_addr   = (RD_LATENCY == 1) ? s.araddr : ar_addr;
    assign rd_sample = (RD_LATENCY == 1) ? ar_hs : ((rd_st == RD_WAIT) && (rd_cnt == 4'd1));
    assign rd_ok     = addr_ok(rd_addr);
    assign s.rresp   = rresp_q;
    assign s.rdata   = ((rd_st == RD_DATA) && (rresp_q == OKAY)) ? rd_q : '0;

    always_comb begin
        rd_nx     = rd_st;
        s.arready = 1'b0;
        s.rvalid  = 1'b0;
        case (rd_st)
            RD_IDLE: begin
                s.arready = live;
                if (ar_hs) rd_nx = (RD_LATENCY == 1) ? RD_DATA : RD_WAIT;
            end
            RD_WAIT: if (rd_cnt == 4'd1) rd_nx = RD_DATA;
            RD_DATA: begin
                s.rvalid = 1'b1;
                if (s.rready) rd_nx = RD_IDLE;
            end
            default: rd_nx = RD_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_st   <= RD_IDLE;
            rd_cnt  <= '0;
            ar_addr <= '0;
            rresp_q <= OKAY;
        end else begin
            rd_st <= rd_nx;
            if (ar_hs) begin
                ar_addr <= s.araddr;
                rd_cnt  <= LAT_LOAD;
            end else if (rd_st == RD_WAIT) begin
                rd_cnt <= rd_cnt - 4'd1;
            end
            if (rd_sample) rresp_q <= rd_ok ? OKAY : DECERR;
        end
    end

    logic [IDX_W-1:0] w_idx, r_idx;
    assign w_idx = IDX_W'(word_index(64'(aw_addr), BASE_ADDR, STRB_W));
    assign r_idx = IDX_W'(word_index(64'(rd_addr), BASE_ADDR, STRB_W));

    axi_lite_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .aclk  (aclk),
        .we    (commit && aw_ok),
        .waddr (w_idx),
        .wdata (w_data),
        .wstrb (w_strb),
        .re    (rd_sample && rd_ok),
        .raddr (r_idx),
        .rdata (rd_q)
    );

`ifdef AXI_LITE_MEM_STATS_EN
    logic        b_done, r_done;
    logic [32:0] err_sum;
    assign b_done  = s.bvalid && s.bready;
    assign r_done  = s.rvalid && s.rready;
    assign err_sum = {1'b0, err_count} + 33'(b_done && (bresp_q == DECERR))
                                       + 33'(r_done && (rresp_q == DECERR));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_count  <= '0;
            rd_count  <= '0;
            err_count <= '0;
        end else begin
            if (b_done && (wr_count != '1)) wr_count <= wr_count + 32'd1;
            if (r_done && (rd_count != '1)) rd_count <= rd_count + 32'd1;
            err_count <= err_sum[32] ? '1 : err_sum[31:0];
        end
    end
`endif
endmodule

// File: tb/tb_axi_lite_mem_slv.sv
// Randomized self-checking bench for axi_lite_mem_slv against a word-array reference model.
module tb_axi_lite_mem_slv;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 64;
    localparam int RD_LAT = 3;
    localparam int BASE   = 'h1000;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    axi_lite_mem_slv_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

`ifdef AXI_LITE_MEM_STATS_EN
    logic [31:0] wr_count, rd_count, err_count;
`endif

    axi_lite_mem_slv #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .RD_LATENCY (RD_LAT),
        .BASE_ADDR  (BASE)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s       (bus)
`ifdef AXI_LITE_MEM_STATS_EN
        ,
        .wr_count  (wr_count),
        .rd_count  (rd_count),
        .err_count (err_count)
`endif
    );

    int checks = 0;
    int errors = 0;
    int n_wr = 0, n_rd = 0, n_err = 0;
    logic [31:0] model [DEPTH];

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic bit in_range(input int a);
        return (a >= BASE) && ((a - BASE) / 4 < DEPTH);
    endfunction

    function automatic logic [1:0] model_write(input int a, input logic [31:0] d, input logic [3:0] st);
        int i;
        if (!in_range(a)) begin
            n_err++;
            return 2'b11;
        end
        i = (a - BASE) / 4;
        for (int b = 0; b < 4; b++)
            if (st[b]) model[i][8*b +: 8] = d[8*b +: 8];
        return 2'b00;
    endfunction

    function automatic void model_read(input int a, output logic [31:0] d, output logic [1:0] r);
        if (!in_range(a)) begin
            n_err++;
            d = '0;
            r = 2'b11;
        end else begin
            d = model[(a - BASE) / 4];
            r = 2'b00;
        end
    endfunction

    // ---------------- bus drivers ----------------
    task automatic send_aw_w(input int a, input logic [31:0] d, input logic [3:0] st, output bit to);
        int n;
        bit aw_r, w_r;
        @(negedge aclk);
        bus.awaddr = ADDR_W'(a); bus.awvalid = 1'b1;
        bus.wdata = d; bus.wstrb = st; bus.wvalid = 1'b1;
        n = 0;
        while ((bus.awvalid || bus.wvalid) && n < 50) begin
            aw_r = bus.awready;
            w_r  = bus.wready;
            @(negedge aclk);
            if (aw_r) bus.awvalid = 1'b0;
            if (w_r)  bus.wvalid  = 1'b0;
            n++;
        end
        to = bus.awvalid || bus.wvalid;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
    endtask

    task automatic get_b(output logic [1:0] resp, output bit to);
        int n;
        bus.bready = 1'b1;
        n = 0;
        while (!bus.bvalid && n < 50) begin
            @(negedge aclk);
            n++;
        end
        to = !bus.bvalid;
        resp = bus.bresp;
        @(negedge aclk);
        bus.bready = 1'b0;
    endtask

    task automatic axi_write(input int a, input logic [31:0] d, input logic [3:0] st,
                             output logic [1:0] resp, output bit to);
        bit t1, t2;
        send_aw_w(a, d, st, t1);
        get_b(resp, t2);
        to = t1 || t2;
        n_wr++;
    endtask

    task automatic axi_read(input int a, output logic [31:0] d, output logic [1:0] resp,
                            output int lat, output bit to);
        int n;
        @(negedge aclk);
        bus.araddr = ADDR_W'(a); bus.arvalid = 1'b1;
        n = 0;
        while (!bus.arready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        @(negedge aclk);
        bus.arvalid = 1'b0;
        lat = 1;
        while (!bus.rvalid && lat < 50) begin
            @(negedge aclk);
            lat++;
        end
        to = !bus.rvalid || (n >= 50);
        d = bus.rdata;
        resp = bus.rresp;
        bus.rready = 1'b1;
        @(negedge aclk);
        bus.rready = 1'b0;
        n_rd++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        checks++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got aw/w/ar/b/r=%b exp 00000",
                     {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
        end
        checks++;
        if ({bus.bresp, bus.rresp} !== 4'b0 || bus.rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got bresp=%b rresp=%b rdata=%h exp 0", bus.bresp, bus.rresp, bus.rdata);
        end
        aresetn = 1'b1;
        @(negedge aclk);
        checks++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_release readies got %b exp 111", {bus.awready, bus.wready, bus.arready});
        end
`ifdef AXI_LITE_MEM_STATS_EN
        checks++;
        if ({wr_count, rd_count, err_count} !== 96'h0) begin
            errors++;
            $display("FAIL reset_stats got %0d/%0d/%0d exp 0", wr_count, rd_count, err_count);
        end
`endif
    endtask

    task automatic test_fill();
        logic [1:0] resp, exp;
        logic [31:0] d;
        bit to;
        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom;
            axi_write(BASE + 4 * i, d, 4'hF, resp, to);
            exp = model_write(BASE + 4 * i, d, 4'hF);
            checks++;
            if (to || resp !== exp) begin
                errors++;
                $display("FAIL fill_bresp word %0d got %b timeout=%0d exp %b", i, resp, to, exp);
            end
        end
    endtask

    task automatic test_basic();
        logic [1:0] resp;
        logic [31:0] d;
        int lat;
        bit to;
        axi_write(BASE + 'h10, 32'hDEADBEEF, 4'hF, resp, to);
        void'(model_write(BASE + 'h10, 32'hDEADBEEF, 4'hF));
        checks++;
        if (to || resp !== 2'b00) begin
            errors++;
            $display("FAIL basic_bresp got %b timeout=%0d exp 00", resp, to);
        end
        axi_read(BASE + 'h10, d, resp, lat, to);
        checks++;
        if (to || d !== 32'hDEADBEEF || resp !== 2'b00) begin
            errors++;
            $display("FAIL basic_read got %h/%b exp deadbeef/00", d, resp);
        end
        checks++;
        if (lat !== RD_LAT) begin
            errors++;
            $display("FAIL basic_latency got %0d exp %0d", lat, RD_LAT);
        end
    endtask

    task automatic test_strobe();
        logic [1:0] resp, exp, er;
        logic [31:0] d, ed;
        logic [3:0] st;
        int a, lat;
        bit to;
        axi_write(BASE + 'h10, 32'h00AA0000, 4'b0100, resp, to);
        void'(model_write(BASE + 'h10, 32'h00AA0000, 4'b0100));
        axi_read(BASE + 'h10, d, resp, lat, to);
        checks++;
        if (to || d !== 32'hDEAABEEF || resp !== 2'b00) begin
            errors++;
            $display("FAIL strobe_merge got %h/%b exp deaabeef/00", d, resp);
        end
        // random addresses (some out of range, unaligned low bits) and strobes including zero
        for (int k = 0; k < 30; k++) begin
            a  = BASE - 32 + int'($urandom_range(0, DEPTH * 4 + 63));
            d  = $urandom;
            st = (k % 7 == 0) ? 4'h0 : 4'($urandom);
            axi_write(a, d, st, resp, to);
            exp = model_write(a, d, st);
            checks++;
            if (to || resp !== exp) begin
                errors++;
                $display("FAIL rand_bresp addr %h got %b exp %b", a, resp, exp);
            end
            if (k % 2 == 1) a = BASE + 4 * int'($urandom_range(0, DEPTH - 1));
            axi_read(a, d, resp, lat, to);
            model_read(a, ed, er);
            checks++;
            if (to || d !== ed || resp !== er) begin
                errors++;
                $display("FAIL rand_read addr %h got %h/%b exp %h/%b", a, d, resp, ed, er);
            end
        end
    endtask

    task automatic test_w_first();
        logic [1:0] resp, exp;
        logic [31:0] d, rd;
        int lat, n;
        bit to;
        d = $urandom;
        @(negedge aclk);
        bus.wdata = d; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        n = 0;
        while (!bus.wready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        @(negedge aclk);
        bus.wvalid = 1'b0;
        repeat (3) begin
            checks++;
            if (bus.wready !== 1'b0 || bus.awready !== 1'b1) begin
                errors++;
                $display("FAIL wfirst_ready got wready=%b awready=%b exp 0/1", bus.wready, bus.awready);
            end
            @(negedge aclk);
        end
        bus.awaddr = ADDR_W'(BASE + 'h20); bus.awvalid = 1'b1;
        @(negedge aclk);
        bus.awvalid = 1'b0;
        checks++;
        if (bus.bvalid !== 1'b0) begin
            errors++;
            $display("FAIL wfirst_bvalid_early got %b exp 0", bus.bvalid);
        end
        @(negedge aclk);
        exp = model_write(BASE + 'h20, d, 4'hF);
        checks++;
        if (bus.bvalid !== 1'b1 || bus.bresp !== exp) begin
            errors++;
            $display("FAIL wfirst_bvalid got %b/%b exp 1/%b", bus.bvalid, bus.bresp, exp);
        end
        get_b(resp, to);
        n_wr++;
        axi_read(BASE + 'h20, rd, resp, lat, to);
        checks++;
        if (to || rd !== d) begin
            errors++;
            $display("FAIL wfirst_readback got %h exp %h", rd, d);
        end
    endtask

    task automatic test_decerr();
        logic [1:0] resp, er;
        logic [31:0] d, ed;
        int lat;
        bit to;
`ifdef AXI_LITE_MEM_STATS_EN
        logic [31:0] e0;
        e0 = err_count;
`endif
        axi_write(BASE + DEPTH * 4, $urandom, 4'hF, resp, to);
        void'(model_write(BASE + DEPTH * 4, 32'h0, 4'hF));
        checks++;
        if (to || resp !== 2'b11) begin
            errors++;
            $display("FAIL decerr_bresp got %b exp 11", resp);
        end
        axi_read(BASE + DEPTH * 4, d, resp, lat, to);
        model_read(BASE + DEPTH * 4, ed, er);
        checks++;
        if (to || resp !== 2'b11 || d !== 32'h0) begin
            errors++;
            $display("FAIL decerr_read got %h/%b exp 0/11", d, resp);
        end
`ifdef AXI_LITE_MEM_STATS_EN
        checks++;
        if (err_count - e0 !== 32'd2) begin
            errors++;
            $display("FAIL decerr_count got %0d exp 2", err_count - e0);
        end
`endif
        for (int k = 0; k < 3; k++) begin
            automatic int a = (k == 0) ? BASE : (k == 1) ? BASE - 4 : BASE + (DEPTH - 1) * 4;
            axi_read(a, d, resp, lat, to);
            model_read(a, ed, er);
            checks++;
            if (to || d !== ed || resp !== er) begin
                errors++;
                $display("FAIL decerr_edge addr %h got %h/%b exp %h/%b", a, d, resp, ed, er);
            end
        end
    endtask

    task automatic test_bready_hold();
        logic [1:0] resp, exp;
        int n;
        bit to;
        send_aw_w(BASE + DEPTH * 4 + 8, $urandom, 4'hF, to);
        exp = model_write(BASE + DEPTH * 4 + 8, 32'h0, 4'hF);
        n = 0;
        while (!bus.bvalid && n < 50) begin
            @(negedge aclk);
            n++;
        end
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (bus.bvalid !== 1'b1 || bus.bresp !== exp || bus.awready !== 1'b0) begin
                errors++;
                $display("FAIL bhold cycle %0d got bvalid=%b bresp=%b awready=%b exp 1/%b/0",
                         c, bus.bvalid, bus.bresp, bus.awready, exp);
            end
            @(negedge aclk);
        end
        get_b(resp, to);
        n_wr++;
        checks++;
        if (bus.awready !== 1'b1) begin
            errors++;
            $display("FAIL bhold_release awready got %b exp 1", bus.awready);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] resp, er;
        logic [31:0] d, ed;
        int a, hs, lat;
        bit rdy, to;
        hs = 0;
        @(negedge aclk);
        bus.bready = 1'b1;
        a = BASE + 4 * int'($urandom_range(0, DEPTH - 1));
        bus.awaddr = ADDR_W'(a); bus.wdata = $urandom; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            rdy = bus.awready && bus.wready;
            if (rdy) begin
                hs++;
                n_wr++;
                void'(model_write(a, bus.wdata, 4'hF));
            end
            @(negedge aclk);
            if (rdy) begin
                a = BASE + 4 * int'($urandom_range(0, DEPTH - 1));
                bus.awaddr = ADDR_W'(a); bus.wdata = $urandom;
            end
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(negedge aclk);
        bus.bready = 1'b0;
        checks++;
        if (hs !== 4) begin
            errors++;
            $display("FAIL b2b_throughput got %0d writes in 12 cycles exp 4", hs);
        end
        for (int k = 0; k < 4; k++) begin
            a = BASE + 4 * int'($urandom_range(0, DEPTH - 1));
            axi_read(a, d, resp, lat, to);
            model_read(a, ed, er);
            checks++;
            if (to || d !== ed || resp !== er) begin
                errors++;
                $display("FAIL b2b_read addr %h got %h/%b exp %h/%b", a, d, resp, ed, er);
            end
        end
    endtask

    task automatic test_stats();
`ifdef AXI_LITE_MEM_STATS_EN
        checks++;
        if (wr_count !== 32'(n_wr) || rd_count !== 32'(n_rd) || err_count !== 32'(n_err)) begin
            errors++;
            $display("FAIL stats got %0d/%0d/%0d exp %0d/%0d/%0d",
                     wr_count, rd_count, err_count, n_wr, n_rd, n_err);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp, er;
        logic [31:0] d, ed;
        int lat, n;
        bit to;
        @(negedge aclk);
        bus.araddr = ADDR_W'(BASE + 'h10); bus.arvalid = 1'b1;
        @(negedge aclk);
        bus.arvalid = 1'b0;
        #2 aresetn = 1'b0;
        n_wr = 0; n_rd = 0; n_err = 0;
        #1;
        checks++;
        if (bus.rvalid !== 1'b0 || bus.arready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_wait got rvalid=%b arready=%b exp 0/0", bus.rvalid, bus.arready);
        end
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        checks++;
        if (bus.arready !== 1'b1 || bus.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_release got arready=%b rvalid=%b exp 1/0", bus.arready, bus.rvalid);
        end
        // reset while a response is being held must drop rvalid without a clock edge
        bus.araddr = ADDR_W'(BASE + 'h20); bus.arvalid = 1'b1;
        @(negedge aclk);
        bus.arvalid = 1'b0;
        n = 0;
        while (!bus.rvalid && n < 50) begin
            @(negedge aclk);
            n++;
        end
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if (n >= 50 || bus.rvalid !== 1'b0 || bus.rdata !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_data got rvalid=%b rdata=%h waited=%0d exp 0/0", bus.rvalid, bus.rdata, n);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        for (int k = 0; k < 2; k++) begin
            automatic int a = (k == 0) ? BASE + 'h10 : BASE + 'h20;
            axi_read(a, d, resp, lat, to);
            model_read(a, ed, er);
            checks++;
            if (to || d !== ed || resp !== er || lat !== RD_LAT) begin
                errors++;
                $display("FAIL rstmid_retain addr %h got %h/%b lat %0d exp %h/%b lat %0d",
                         a, d, resp, lat, ed, er, RD_LAT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_basic();
        test_strobe();
        test_w_first();
        test_decerr();
        test_bready_hold();
        test_back_to_back();
        test_stats();
        test_reset_mid();
        test_stats();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_lite_mem_slv.md
Name: axi_lite_mem_slv

Overview:
- Parametrised AXI4-Lite slave with an internal word-addressed memory model and configurable read latency.
- Replaces fixed-size VIP slave memory models in block-level AXI simulation tops; also synthesizable.
- Adds address-range decode with error responses, byte strobes and independent read/write paths.

Parameters:
DATA_W, 32, data bus width; must be 32 or 64.
ADDR_W, 16, byte address width.
DEPTH, 1024, number of DATA_W-bit words; power of two not required.
RD_LATENCY, 1, cycles from AR handshake to RVALID assertion; range 1..15.
BASE_ADDR, 0, byte address of word 0; must be DATA_W/8-aligned.

Ports:
aclk  in  1  clock
aresetn  in  1  reset
s_awaddr  in  ADDR_W  write address
s_awvalid  in  1  AW valid
s_awready  out  1  AW ready
s_wdata  in  DATA_W  write data
s_wstrb  in  DATA_W/8  byte enables
s_wvalid  in  1  W valid
s_wready  out  1  W ready
s_bresp  out  2  write response
s_bvalid  out  1  B valid
s_bready  in  1  B ready
s_araddr  in  ADDR_W  read address
s_arvalid  in  1  AR valid
s_arready  out  1  AR ready
s_rdata  out  DATA_W  read data
s_rresp  out  2  read response
s_rvalid  out  1  R valid
s_rready  in  1  R ready

Behaviour:
- One clock, aclk. Reset aresetn is asynchronous, active-low.
- Reset values: all *ready, s_bvalid and s_rvalid are 0; s_bresp, s_rresp and s_rdata are 0. The memory array is not reset.
- Ready signals rise in the first cycle after aresetn deasserts.
- Write FSM states: WR_IDLE, WR_RESP.
  - In WR_IDLE, s_awready and s_wready are each 1 until their own handshake occurs. AW and W are latched independently, in either order or in the same cycle.
  - The cycle after both are latched, the memory commits per s_wstrb byte lanes. In that same edge the FSM enters WR_RESP with s_bvalid=1.
  - s_bvalid, s_bresp hold until s_bready; then the FSM returns to WR_IDLE with both readies 1 next cycle.
  - With s_bready tied 1: one write per 3 cycles max.
- Read FSM states: RD_IDLE, RD_WAIT, RD_DATA.
  - In RD_IDLE, s_arready=1. On handshake the FSM latches the address, loads the counter with RD_LATENCY-1 and enters RD_WAIT, or RD_DATA directly if RD_LATENCY=1.
  - The counter decrements in RD_WAIT and moves to RD_DATA at 0.
  - Memory is sampled on the RD_WAIT→RD_DATA edge, or the AR-handshake edge for latency 1. s_rvalid=1 appears RD_LATENCY cycles after the AR handshake.
  - s_rdata, s_rresp hold until s_rready; then back to RD_IDLE.
- Decode: word index = (addr - BASE_ADDR) >> log2(DATA_W/8). Low address bits are ignored (no misalignment error).
  - addr < BASE_ADDR or index >= DEPTH: response DECERR (2'b11). Writes are dropped; reads return rdata 0.
  - Otherwise OKAY (2'b00). SLVERR is never generated.
- Read/write collision: if the write commit and read sample hit the same word in the same cycle, the read returns new data (write-first).
- wstrb=0: response OKAY, memory unchanged.
- aresetn asserted mid-transaction: both FSMs go to idle immediately, pending responses are discarded, and memory contents are retained.

Optional Feature:
- Macro AXI_LITE_MEM_STATS_EN.
- Defined: adds outputs wr_count, rd_count and err_count, each 32 bits. These count completed B handshakes, completed R handshakes, and DECERR responses (either channel).
  - Counters saturate at all-ones and reset to 0.
- Undefined: these ports and counters do not exist.

Decomposition:
- Package axi_lite_mem_pkg holds:
  - resp_t enum (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11);
  - wr_state_t and rd_state_t enums;
  - function word_index(addr, base, bytes).
- Sub-module axi_lite_mem_array: single-clock, one write port with byte enables, one read port, write-first on same-address collision, DEPTH x DATA_W.

Test Plan:
- Write 0xDEADBEEF to BASE_ADDR+0x10, wstrb 4'hF, then read BASE_ADDR+0x10 with RD_LATENCY=3. Require: bresp 00, rdata 0xDEADBEEF, rvalid exactly 3 cycles after the AR handshake.
- Start from 0xDEADBEEF and write 0x00AA0000 with wstrb 4'b0100, then read. Require: rdata 0xDEAABEEF.
- Present W 4 cycles before AW. Require: wready drops after the W handshake, and bvalid asserts 1 cycle after the AW handshake.
- Read and write at address BASE_ADDR+DEPTH*4 (32-bit build). Require: bresp 11, rresp 11, rdata 0. A subsequent read of word 0 is unchanged. With AXI_LITE_MEM_STATS_EN, err_count=2.
- Hold bready=0 for 10 cycles. Require: bvalid and bresp stable and awready=0 throughout.
- Assert aresetn mid-RD_WAIT. Require: rvalid 0 asynchronously, arready 1 in the first cycle after release, and earlier written data still readable.
